fcc_mem_rd_arb: RTL and testbench
=================================

Name: fcc_mem_rd_arb

Overview:
- Shares the single memory read port between the three FCC read clients: pic (data vector, id 0), wgt (weights, id 1) and bias (id 2).
- Each client issues a burst request with start address and byte count. The arbiter grants one client at a time using round-robin and forwards the request to memory.
- Returned beats are steered back to the granted client until the last beat.
- Sits between the fcc core's three read interfaces and the memory controller read port.

Parameters:
- ADDR_WIDTH, 19, byte address width.
- SIZE_WIDTH, 5, width of the size_bytes field (LOG2_MAX_BYTES_TO_RD).
- DATA_WIDTH, 256, read data bus width (32 words x 8 bits).
- LV_WIDTH, 5, width of last_valid (index of the last valid byte in the final beat).

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- rq_req  in  3  per-client request; bit0=pic, bit1=wgt, bit2=bias.
- rq_start_addr  in  3*ADDR_WIDTH  per-client start address; client k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- rq_size_bytes  in  3*SIZE_WIDTH  per-client burst length in bytes, same slicing.
- rq_valid  out  3  one-hot data-valid toward the granted client.
- rq_last  out  3  one-hot last-beat marker toward the granted client.
- rq_data  out  DATA_WIDTH  read data, broadcast to all clients.
- rq_last_valid  out  LV_WIDTH  last-beat valid-byte index, broadcast.
- mem_req  out  1  memory read request.
- mem_start_addr  out  ADDR_WIDTH  latched address of the granted client.
- mem_size_bytes  out  SIZE_WIDTH  latched size of the granted client.
- mem_valid  in  1  memory data beat valid.
- mem_last  in  1  memory last beat.
- mem_data  in  DATA_WIDTH  memory read data.
- mem_last_valid  in  LV_WIDTH  memory last-valid index.
- arb_busy  out  1  high whenever state != IDLE.
- arb_gnt_id  out  2  id of the current or most recent grant.
- err_stray  out  1  sticky flag: mem_valid seen while in IDLE.

Behaviour:
- Reset values: all outputs 0. Round-robin pointer last_gnt=2, so pic has top priority after reset. State=IDLE.
- Clock and reset: single clk domain. rst_n is asynchronous, active-low.
- FSM states: IDLE, ISSUE, DATA, ZERO.
- IDLE: if rq_req!=0, pick the first set bit searching from (last_gnt+1) mod 3 upward with wrap. Latch that client's addr and size into mem_start_addr/mem_size_bytes. Set arb_gnt_id and last_gnt.
  - If the latched size is 0, go to ZERO; otherwise go to ISSUE.
- ISSUE: mem_req=1 (registered), so mem_req rises 1 cycle after rq_req is sampled in IDLE.
  - mem_req is held high until the first cycle mem_valid=1; it deasserts the cycle after.
  - State moves to DATA on that first mem_valid.
  - The first beat is forwarded in the same cycle it arrives, including while still in ISSUE.
- DATA forwarding is combinational, zero latency:
  - rq_valid[g]=mem_valid, rq_last[g]=mem_valid&mem_last, for granted id g only.
  - rq_data=mem_data and rq_last_valid=mem_last_valid at all times.
  - On mem_valid&mem_last, return to IDLE. One bubble cycle (IDLE) precedes the next grant.
  - A single-beat burst (mem_valid&mem_last in ISSUE) goes straight to IDLE.
- ZERO: size-0 requests are completed locally with no memory access. Drive a one-cycle rq_valid[g]=rq_last[g]=1 and rq_last_valid=0, then go to IDLE.
- Request hold:
  - A client holds rq_req until it sees its rq_last.
  - Deasserting rq_req mid-burst does not abort; the burst completes and beats are still steered to it.
  - A request still asserted in the cycle after its own rq_last is treated as a new request.
- Fairness: with several clients pending, grants rotate pic->wgt->bias. No client is granted twice in a row while another is pending.
- Stray data: mem_valid in IDLE sets err_stray (sticky until reset). No rq_valid is driven.
- Reset mid-burst: immediately returns to IDLE with mem_req=0, rq_valid=0 and the pointer restored to last_gnt=2. Late memory beats after reset set err_stray.
- Request changes: rq_start_addr/rq_size_bytes changes after the grant cycle do not affect the latched mem_* values.

Test Plan:
- Single pic request, addr=0x00020, size=20, memory returns 1 beat with last, last_valid=19 -> mem_req high at cycle N+1, mem_start_addr=0x00020, mem_size_bytes=20; rq_valid=3'b001 with rq_last=3'b001 in the data cycle; arb_gnt_id=0.
- All three requests asserted together, each burst 2 beats -> grant order pic, wgt, bias; no valid leaks to non-granted bits; one IDLE bubble between bursts.
- wgt re-requests immediately after its burst while pic is pending (last_gnt=1 from prior) -> bias wins if pending, otherwise pic; wgt is not granted back-to-back.
- Memory delays mem_valid 10 cycles after mem_req -> mem_req stays high all 10 cycles, falls the cycle after the first beat.
- bias request with size=0 -> no mem_req; rq_valid=rq_last=3'b100 for exactly 1 cycle; rq_last_valid=0.
- Assert rst_n low during DATA of a 3-beat wgt burst, then inject one more mem_valid after release -> outputs 0 during reset; err_stray=1 after the stray beat; next pic request granted first.

Source files
------------

// File: rtl/fcc_mem_rd_arb.sv
// Round-robin arbiter that shares one memory read port among the pic/wgt/bias clients.
// mem_req is registered (1 cycle after grant); beats return combinationally with no backpressure.
module fcc_mem_rd_arb #(
  parameter int ADDR_WIDTH = 19,
  parameter int SIZE_WIDTH = 5,
  parameter int DATA_WIDTH = 256,
  parameter int LV_WIDTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                rq_req,
  input  logic [3*ADDR_WIDTH-1:0]   rq_start_addr,
  input  logic [3*SIZE_WIDTH-1:0]   rq_size_bytes,
  output logic [2:0]                rq_valid,
  output logic [2:0]                rq_last,
  output logic [DATA_WIDTH-1:0]     rq_data,
  output logic [LV_WIDTH-1:0]       rq_last_valid,
  output logic                      mem_req,
  output logic [ADDR_WIDTH-1:0]     mem_start_addr,
  output logic [SIZE_WIDTH-1:0]     mem_size_bytes,
  input  logic                      mem_valid,
  input  logic                      mem_last,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  input  logic [LV_WIDTH-1:0]       mem_last_valid,
  output logic                      arb_busy,
  output logic [1:0]                arb_gnt_id,
  output logic                      err_stray
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DATA  = 2'd2,
    S_ZERO  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [1:0]              r_last_gnt;
  logic [1:0]              r_gnt_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [SIZE_WIDTH-1:0]   r_size;
  logic                    r_mem_req;
  logic                    r_err_stray;

  logic                    w_any;
  logic [1:0]              w_pick;
  logic [ADDR_WIDTH-1:0]   w_pick_addr;
  logic [SIZE_WIDTH-1:0]   w_pick_size;
  logic [2:0]              w_onehot;
  logic                    w_grant;

  assign w_any   = |rq_req;
  assign w_grant = (r_state == S_IDLE) && w_any;

  // Search starts one past the previous winner and wraps.
  always_comb begin
    w_pick = 2'd0;
    case (r_last_gnt)
      2'd0: begin
        if (rq_req[1])      w_pick = 2'd1;
        else if (rq_req[2]) w_pick = 2'd2;
        else                w_pick = 2'd0;
      end
      2'd1: begin
        if (rq_req[2])      w_pick = 2'd2;
        else if (rq_req[0]) w_pick = 2'd0;
        else                w_pick = 2'd1;
      end
      default: begin
        if (rq_req[0])      w_pick = 2'd0;
        else if (rq_req[1]) w_pick = 2'd1;
        else                w_pick = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_pick_addr = rq_start_addr[0 +: ADDR_WIDTH];
    w_pick_size = rq_size_bytes[0 +: SIZE_WIDTH];
    case (w_pick)
      2'd1: begin
        w_pick_addr = rq_start_addr[ADDR_WIDTH +: ADDR_WIDTH];
        w_pick_size = rq_size_bytes[SIZE_WIDTH +: SIZE_WIDTH];
      end
      2'd2: begin
        w_pick_addr = rq_start_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        w_pick_size = rq_size_bytes[2*SIZE_WIDTH +: SIZE_WIDTH];
      end
      default: begin
        w_pick_addr = rq_start_addr[0 +: ADDR_WIDTH];
        w_pick_size = rq_size_bytes[0 +: SIZE_WIDTH];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = (w_pick_size == '0) ? S_ZERO : S_ISSUE;
      end
      S_ISSUE: begin
        if (mem_valid) w_next = mem_last ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (mem_valid && mem_last) w_next = S_IDLE;
      end
      S_ZERO: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt  <= 2'd2;
      r_gnt_id    <= 2'd0;
      r_addr      <= '0;
      r_size      <= '0;
      r_mem_req   <= 1'b0;
      r_err_stray <= 1'b0;
    end else begin
      r_mem_req <= (w_next == S_ISSUE);
      if (w_grant) begin
        r_last_gnt <= w_pick;
        r_gnt_id   <= w_pick;
        r_addr     <= w_pick_addr;
        r_size     <= w_pick_size;
      end
      if ((r_state == S_IDLE) && mem_valid) begin
        r_err_stray <= 1'b1;
      end
    end
  end

  assign w_onehot = 3'b001 << r_gnt_id;

  // Size-0 bursts are answered locally with a single last beat.
  always_comb begin
    rq_valid      = 3'b000;
    rq_last       = 3'b000;
    rq_last_valid = mem_last_valid;
    case (r_state)
      S_ISSUE, S_DATA: begin
        rq_valid = w_onehot & {3{mem_valid}};
        rq_last  = w_onehot & {3{mem_valid & mem_last}};
      end
      S_ZERO: begin
        rq_valid      = w_onehot;
        rq_last       = w_onehot;
        rq_last_valid = '0;
      end
      default: begin
        rq_valid = 3'b000;
        rq_last  = 3'b000;
      end
    endcase
  end

  assign rq_data        = mem_data;
  assign mem_req        = r_mem_req;
  assign mem_start_addr = r_addr;
  assign mem_size_bytes = r_size;
  assign arb_busy       = (r_state != S_IDLE);
  assign arb_gnt_id     = r_gnt_id;
  assign err_stray      = r_err_stray;

  a_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rq_valid));
  a_req_in_issue: assert property (@(posedge clk) disable iff (!rst_n) r_mem_req |-> (r_state == S_ISSUE));

endmodule

// File: tb/tb_fcc_mem_rd_arb.sv
// Randomized bench for fcc_mem_rd_arb checked every cycle against a transaction-level model.
module tb_fcc_mem_rd_arb;
  localparam int AW = 19;
  localparam int SW = 5;
  localparam int DW = 256;
  localparam int LW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [2:0]        rq_req;
  logic [3*AW-1:0]   rq_start_addr;
  logic [3*SW-1:0]   rq_size_bytes;
  logic [2:0]        rq_valid;
  logic [2:0]        rq_last;
  logic [DW-1:0]     rq_data;
  logic [LW-1:0]     rq_last_valid;
  logic              mem_req;
  logic [AW-1:0]     mem_start_addr;
  logic [SW-1:0]     mem_size_bytes;
  logic              mem_valid;
  logic              mem_last;
  logic [DW-1:0]     mem_data;
  logic [LW-1:0]     mem_last_valid;
  logic              arb_busy;
  logic [1:0]        arb_gnt_id;
  logic              err_stray;

  fcc_mem_rd_arb #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW), .LV_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq_req(rq_req), .rq_start_addr(rq_start_addr), .rq_size_bytes(rq_size_bytes),
    .rq_valid(rq_valid), .rq_last(rq_last), .rq_data(rq_data), .rq_last_valid(rq_last_valid),
    .mem_req(mem_req), .mem_start_addr(mem_start_addr), .mem_size_bytes(mem_size_bytes),
    .mem_valid(mem_valid), .mem_last(mem_last), .mem_data(mem_data), .mem_last_valid(mem_last_valid),
    .arb_busy(arb_busy), .arb_gnt_id(arb_gnt_id), .err_stray(err_stray)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: which client owns the port (-1 = none), whether it is a local size-0
  // completion, and whether memory has delivered its first beat yet.
  int            m_owner, m_last, m_gid;
  bit            m_local, m_seen, m_err;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_size;

  bit   rs_active, rs_first, rs_gaps;
  int   rs_delay, rs_beats, rs_dmax, rs_bmin, rs_bmax;
  logic [2:0] pend, prev_last;
  logic prev_mreq;
  int   gq[$];

  task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 2; m_gid = 0;
    m_local = 0; m_seen = 0; m_err = 0;
    m_addr = '0; m_size = '0;
  endtask

  task automatic model_update();
    int pick;
    int c;
    bit found;
    if (m_owner < 0) begin
      if (mem_valid) m_err = 1;
      found = 0; pick = 0;
      for (int off = 1; off <= 3; off++) begin
        c = (m_last + off) % 3;
        if (!found && rq_req[c]) begin found = 1; pick = c; end
      end
      if (found) begin
        m_owner = pick; m_last = pick; m_gid = pick;
        m_addr  = rq_start_addr[pick*AW +: AW];
        m_size  = rq_size_bytes[pick*SW +: SW];
        m_local = (m_size == '0);
        m_seen  = 0;
      end
    end else if (m_local) begin
      m_owner = -1;
    end else if (mem_valid) begin
      m_seen = 1;
      if (mem_last) m_owner = -1;
    end
  endtask

  // Called at the negedge: compare all outputs, advance the model, move to posedge+1.
  task automatic step();
    logic [2:0]    e_v, e_l;
    logic [LW-1:0] e_lv;
    logic          e_busy, e_req;
    if (!rst_n) model_reset();
    e_busy = (m_owner >= 0);
    e_req  = e_busy && !m_local && !m_seen;
    e_v = 3'b000; e_l = 3'b000;
    if (e_busy) begin
      if (m_local) begin
        e_v = 3'b001 << m_owner; e_l = 3'b001 << m_owner;
      end else begin
        e_v = {2'b00, mem_valid} << m_owner;
        e_l = {2'b00, mem_valid & mem_last} << m_owner;
      end
    end
    e_lv = (e_busy && m_local) ? '0 : mem_last_valid;
    cmp("rq_valid", DW'(rq_valid), DW'(e_v));
    cmp("rq_last", DW'(rq_last), DW'(e_l));
    cmp("rq_data", rq_data, mem_data);
    cmp("rq_last_valid", DW'(rq_last_valid), DW'(e_lv));
    cmp("mem_req", DW'(mem_req), DW'(e_req));
    cmp("mem_start_addr", DW'(mem_start_addr), DW'(m_addr));
    cmp("mem_size_bytes", DW'(mem_size_bytes), DW'(m_size));
    cmp("arb_busy", DW'(arb_busy), DW'(e_busy));
    cmp("arb_gnt_id", DW'(arb_gnt_id), DW'(m_gid));
    cmp("err_stray", DW'(err_stray), DW'(m_err));
    prev_last = e_l;
    if (rst_n) model_update();
    @(posedge clk); #1;
  endtask

  task automatic drive_mem(input bit rnd);
    mem_valid = 1'b0;
    mem_last  = 1'($urandom);
    for (int i = 0; i < 8; i++) mem_data[i*32 +: 32] = $urandom;
    mem_last_valid = LW'($urandom);
    if (m_owner >= 0 && !m_local) begin
      if (!rs_active) begin
        rs_active = 1; rs_first = 1;
        rs_delay = $urandom_range(rs_dmax, 0);
        rs_beats = $urandom_range(rs_bmax, rs_bmin);
      end
      if (rs_delay > 0) begin
        rs_delay--;
      end else if (rs_first || !rs_gaps || ($urandom % 3 != 0)) begin
        mem_valid = 1'b1; rs_first = 0; rs_beats--;
        mem_last = (rs_beats == 0);
        if (rs_beats == 0) rs_active = 0;
      end
    end else if (rnd && ($urandom % 60 == 0)) begin
      mem_valid = 1'b1;
    end
  endtask

  task automatic auto_cycle(input bit rnd);
    rst_n = rnd ? ($urandom % 400 != 0) : 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (prev_last[k])            pend[k] = rnd && ($urandom % 4 == 0);
      else if (rnd && !pend[k])    pend[k] = ($urandom % 6 == 0);
      else if (rnd && m_owner == k && ($urandom % 40 == 0)) pend[k] = 1'b0;
      if (rnd && ($urandom % 3 == 0)) begin
        rq_start_addr[k*AW +: AW] = AW'($urandom);
        rq_size_bytes[k*SW +: SW] = ($urandom % 6 == 0) ? '0 : SW'($urandom_range(31, 1));
      end
    end
    rq_req = pend;
    drive_mem(rnd);
    if (!rst_n) rs_active = 0;
    @(negedge clk);
    if (mem_req && !prev_mreq) gq.push_back(int'(arb_gnt_id));
    prev_mreq = mem_req;
    step();
  endtask

  task automatic drain(input string nm);
    int i;
    i = 0;
    while ((pend != 3'b000 || m_owner >= 0) && i < 300) begin
      auto_cycle(1'b0);
      i++;
    end
    if (pend != 3'b000 || m_owner >= 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: still busy after %0d cycles, want idle", nm, i);
    end
  endtask

  task automatic quiet(input logic [2:0] req, input logic v, input logic l);
    rq_req = req; mem_valid = v; mem_last = l;
    mem_data = {8{32'h5a5a_0000 + 32'($urandom_range(255, 0))}};
  endtask

  initial begin
    int exp_order[3];
    exp_order = '{0, 1, 2};
    rst_n = 1'b0; rq_req = '0; rq_start_addr = '0; rq_size_bytes = '0;
    mem_valid = 0; mem_last = 0; mem_data = '0; mem_last_valid = '0;
    pend = '0; prev_last = '0; prev_mreq = 0;
    rs_active = 0; rs_first = 0; rs_gaps = 0; rs_delay = 0; rs_beats = 0;
    rs_dmax = 0; rs_bmin = 2; rs_bmax = 2;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    cmp("lit_rst_valid", DW'(rq_valid), DW'(3'b000));
    cmp("lit_rst_mem_req", DW'(mem_req), DW'(1'b0));
    cmp("lit_rst_busy", DW'(arb_busy), DW'(1'b0));
    cmp("lit_rst_gnt", DW'(arb_gnt_id), DW'(2'd0));
    cmp("lit_rst_err", DW'(err_stray), DW'(1'b0));
    cmp("lit_rst_addr", DW'(mem_start_addr), DW'(19'h0));
    step();
    rst_n = 1'b1;

    // All three clients together, 2-beat bursts: order must be pic, wgt, bias.
    rq_start_addr = {19'h3_0000, 19'h2_0000, 19'h1_0000};
    rq_size_bytes = {5'd24, 5'd16, 5'd8};
    pend = 3'b111; gq.delete(); prev_mreq = 0;
    drain("all3");
    cmp("lit_order_cnt", DW'(gq.size()), DW'(3));
    for (int i = 0; i < 3; i++)
      cmp("lit_order", DW'((i < gq.size()) ? gq[i] : -1), DW'(exp_order[i]));

    // Single pic beat: addr 0x20, size 20, last_valid 19.
    rq_start_addr[0 +: AW] = 19'h00020; rq_size_bytes[0 +: SW] = 5'd20;
    quiet(3'b001, 0, 0);
    @(negedge clk); cmp("lit_t1_req0", DW'(mem_req), DW'(1'b0)); step();
    rq_start_addr[0 +: AW] = 19'h7ffff; rq_size_bytes[0 +: SW] = 5'd3;
    quiet(3'b001, 0, 0);
    @(negedge clk);
    cmp("lit_t1_req1", DW'(mem_req), DW'(1'b1));
    cmp("lit_t1_addr", DW'(mem_start_addr), DW'(19'h00020));
    cmp("lit_t1_size", DW'(mem_size_bytes), DW'(5'd20));
    cmp("lit_t1_gnt", DW'(arb_gnt_id), DW'(2'd0));
    step();
    quiet(3'b001, 1, 1); mem_last_valid = 5'd19;
    @(negedge clk);
    cmp("lit_t1_valid", DW'(rq_valid), DW'(3'b001));
    cmp("lit_t1_last", DW'(rq_last), DW'(3'b001));
    cmp("lit_t1_lv", DW'(rq_last_valid), DW'(5'd19));
    step();
    quiet(3'b000, 0, 0);
    @(negedge clk);
    cmp("lit_t1_idle_req", DW'(mem_req), DW'(1'b0));
    cmp("lit_t1_idle_busy", DW'(arb_busy), DW'(1'b0));
    step();

    // bias with size 0: local one-cycle completion.
    rq_size_bytes[2*SW +: SW] = 5'd0;
    quiet(3'b100, 0, 0); mem_last_valid = 5'd7;
    @(negedge clk); step();
    quiet(3'b100, 0, 0); mem_last_valid = 5'd7;
    @(negedge clk);
    cmp("lit_z_valid", DW'(rq_valid), DW'(3'b100));
    cmp("lit_z_last", DW'(rq_last), DW'(3'b100));
    cmp("lit_z_lv", DW'(rq_last_valid), DW'(5'd0));
    cmp("lit_z_req", DW'(mem_req), DW'(1'b0));
    step();
    quiet(3'b000, 0, 0);
    @(negedge clk); cmp("lit_z_after", DW'(rq_valid), DW'(3'b000)); step();

    // wgt with memory latency of 10 cycles.
    rq_size_bytes[SW +: SW] = 5'd9;
    quiet(3'b010, 0, 0);
    @(negedge clk); step();
    for (int i = 0; i < 10; i++) begin
      quiet(3'b010, 0, 0);
      @(negedge clk); cmp("lit_d_req_hold", DW'(mem_req), DW'(1'b1)); step();
    end
    quiet(3'b010, 1, 0);
    @(negedge clk);
    cmp("lit_d_req_first", DW'(mem_req), DW'(1'b1));
    cmp("lit_d_valid", DW'(rq_valid), DW'(3'b010));
    step();
    quiet(3'b010, 1, 1);
    @(negedge clk);
    cmp("lit_d_req_fall", DW'(mem_req), DW'(1'b0));
    cmp("lit_d_last", DW'(rq_last), DW'(3'b010));
    step();
    // wgt re-requests at once with pic pending; pic must win.
    quiet(3'b011, 0, 0);
    @(negedge clk); cmp("lit_rr_bubble", DW'(arb_busy), DW'(1'b0)); step();
    quiet(3'b011, 0, 0);
    @(negedge clk);
    cmp("lit_rr_gnt", DW'(arb_gnt_id), DW'(2'd0));
    cmp("lit_rr_req", DW'(mem_req), DW'(1'b1));
    step();
    rs_dmax = 3; rs_bmin = 1; rs_bmax = 3; rs_gaps = 1;
    pend = 3'b011; prev_last = 3'b000;
    drain("rr");

    // Reset in the middle of a 3-beat wgt burst, then a late beat.
    rq_size_bytes[SW +: SW] = 5'd30;
    quiet(3'b010, 0, 0); @(negedge clk); step();
    quiet(3'b010, 1, 0); @(negedge clk); step();
    rst_n = 1'b0; quiet(3'b010, 1, 0);
    @(negedge clk);
    cmp("lit_r_valid", DW'(rq_valid), DW'(3'b000));
    cmp("lit_r_req", DW'(mem_req), DW'(1'b0));
    cmp("lit_r_busy", DW'(arb_busy), DW'(1'b0));
    step();
    quiet(3'b010, 1, 0); @(negedge clk); step();
    rst_n = 1'b1; quiet(3'b000, 1, 1);
    @(negedge clk); cmp("lit_r_err0", DW'(err_stray), DW'(1'b0)); step();
    quiet(3'b111, 0, 0);
    @(negedge clk); cmp("lit_r_err1", DW'(err_stray), DW'(1'b1)); step();
    quiet(3'b111, 0, 0);
    @(negedge clk);
    cmp("lit_r_gnt", DW'(arb_gnt_id), DW'(2'd0));
    cmp("lit_r_busy1", DW'(arb_busy), DW'(1'b1));
    step();
    pend = 3'b111; prev_last = 3'b000;
    drain("rst");

    // Randomized traffic.
    rs_dmax = 12; rs_bmin = 1; rs_bmax = 4; rs_gaps = 1;
    for (int i = 0; i < 3000; i++) auto_cycle(1'b1);
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
